// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, oversampling constants and baud divisor helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int OSR = 16;
    localparam int SAMPLE_LO = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI = 9;
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OSR);
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle strobe every DIV clocks; restart realigns so the next tick lands DIV clocks later
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic restart,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = !restart && (cnt_q == W'(DIV - 1));
    assign cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge iCLK) begin
        if (!iRST_N) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_debug.sv
// uart_rx_debug: 8N1 UART receiver, 16x oversampled with 3-sample majority vote,
// one-byte holding register with valid/ready handshake and error pulses
module uart_rx_debug
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115200,
    parameter int DIV = calc_div(CLK_HZ, BAUD)
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRXD,
    output logic [7:0] oDATA,
    output logic       oVALID,
    input  logic       iREADY,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN
);
    state_t state_q, state_d;
    logic rx_meta_q, rxs_q;
    logic [3:0] os_q, os_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic s_lo_q, s_lo_d, s_mid_q, s_mid_d;
    logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic restart, tick, vote, at_hi, at_end, deliver, accept;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .restart(restart),
        .tick(tick)
    );

    assign restart = (state_q == IDLE) && !rxs_q;
    assign vote = (s_lo_q & s_mid_q) | (s_lo_q & rxs_q) | (s_mid_q & rxs_q);
    assign at_hi = tick && (os_q == 4'(SAMPLE_HI));
    assign at_end = tick && (os_q == 4'(OSR - 1));

    always_comb begin
        state_d = state_q;
        os_d = restart ? 4'd0 : (tick ? os_q + 4'd1 : os_q);
        bit_d = restart ? 3'd0 : bit_q;
        shift_d = shift_q;
        s_lo_d = (tick && os_q == 4'(SAMPLE_LO)) ? rxs_q : s_lo_q;
        s_mid_d = (tick && os_q == 4'(SAMPLE_MID)) ? rxs_q : s_mid_q;
        deliver = 1'b0;
        ferr_d = 1'b0;
        case (state_q)
            IDLE: state_d = restart ? START : IDLE;
            START: state_d = (at_hi && vote) ? IDLE : (at_end ? DATA : START);
            DATA: begin
                shift_d = at_hi ? {vote, shift_q[7:1]} : shift_q;
                bit_d = at_end ? bit_q + 3'd1 : bit_q;
                state_d = (at_end && bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                deliver = at_hi && vote;
                ferr_d = at_hi && !vote;
                state_d = at_hi ? (vote ? IDLE : BREAK) : STOP;
            end
            BREAK: state_d = rxs_q ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
        // A byte may load into a full holding register only if the consumer empties it this cycle
        accept = deliver && (!valid_q || iREADY);
        ovr_d = deliver && !accept;
        valid_d = accept || (valid_q && !iREADY);
        data_d = accept ? shift_q : data_q;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            rx_meta_q <= 1'b1;
            rxs_q <= 1'b1;
            os_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            s_lo_q <= 1'b1;
            s_mid_q <= 1'b1;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_meta_q <= iRXD;
            rxs_q <= rx_meta_q;
            os_q <= os_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            data_q <= data_d;
            s_lo_q <= s_lo_d;
            s_mid_q <= s_mid_d;
            valid_q <= valid_d;
            ferr_q <= ferr_d;
            ovr_q <= ovr_d;
        end
    end

    assign oDATA = data_q;
    assign oVALID = valid_q;
    assign oFRAME_ERR = ferr_q;
    assign oOVERRUN = ovr_q;
endmodule

// File: tb/tb_uart_rx_debug.sv
// tb_uart_rx_debug: directed and random frames against a holding-register level model of the receiver
module tb_uart_rx_debug;
    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    logic iRXD = 1'b1;
    logic iREADY = 1'b1;
    logic [7:0] oDATA;
    logic oVALID, oFRAME_ERR, oOVERRUN;

    uart_rx_debug #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .iRXD(iRXD),
        .oDATA(oDATA),
        .oVALID(oVALID),
        .iREADY(iREADY),
        .oFRAME_ERR(oFRAME_ERR),
        .oOVERRUN(oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0, n_fail = 0;
    int n_ferr = 0, n_ovr = 0, n_rise = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_rise = 0;
    logic ref_full = 1'b0;
    logic [7:0] ref_data = 8'h00;
    logic [7:0] exp_q[$];

    always begin
        @(negedge iCLK);
        #1;
        if (oFRAME_ERR === 1'b1) n_ferr++;
        if (oOVERRUN === 1'b1) n_ovr++;
        if (oVALID === 1'b1 && prev_valid !== 1'b1) n_rise++;
        if (oVALID === 1'b1 && iREADY === 1'b1) got_q.push_back(oDATA);
        prev_valid = oVALID;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Holding-register abstraction: a good frame with ready high is consumed at once,
    // otherwise it fills an empty register or is lost as an overrun
    function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic rdy);
        if (!stop_ok) exp_ferr++;
        else if (rdy) begin exp_q.push_back(b); exp_rise++; end
        else if (!ref_full) begin ref_full = 1'b1; ref_data = b; exp_rise++; end
        else exp_ovr++;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ferr"}, n_ferr, exp_ferr);
        chk({tag, "_ovr"}, n_ovr, exp_ovr);
        chk({tag, "_rise"}, n_rise, exp_rise);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            iRXD = f[i];
            repeat (16) @(negedge iCLK);
        end
    endtask

    task automatic idle(input int n);
        iRXD = 1'b1;
        repeat (n) @(negedge iCLK);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        repeat (3) @(negedge iCLK);
        chk("rst_data", oDATA, 8'h00);
        chk("rst_valid", oVALID, 1'b0);
        chk("rst_ferr", oFRAME_ERR, 1'b0);
        chk("rst_ovr", oOVERRUN, 1'b0);
        iRST_N = 1'b1;
        idle(50);
        check_all("idle");

        lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            for (int c = 1; c <= 200; c++) begin
                @(negedge iCLK);
                if (oVALID === 1'b1) begin lat = c; break; end
            end
        join
        model_frame(8'hA5, 1'b1, 1'b1);
        idle(5);
        n_chk++;
        assert (lat >= 156 && lat <= 158) else begin
            n_fail++;
            $error("FAIL latency: observed %0d expected 156..158", lat);
        end
        check_all("a5");

        iRXD = 1'b0;
        repeat (4) @(negedge iCLK);
        idle(30);
        check_all("glitch");
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b1);
        idle(5);
        check_all("after_glitch");

        send_frame(8'h55, 1'b0);
        iRXD = 1'b0;
        repeat (40) @(negedge iCLK);
        idle(20);
        model_frame(8'h55, 1'b0, 1'b1);
        check_all("frame_err");
        send_frame(8'h01, 1'b1);
        model_frame(8'h01, 1'b1, 1'b1);
        idle(5);
        check_all("after_ferr");

        iREADY = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        chk("ovr_data", oDATA, ref_data);
        chk("ovr_valid", oVALID, ref_full);
        check_all("overrun");
        iREADY = 1'b1;
        @(negedge iCLK);
        iREADY = 1'b0;
        exp_q.push_back(ref_data);
        ref_full = 1'b0;
        chk("ready_clears", oVALID, ref_full);
        iREADY = 1'b1;
        idle(5);
        check_all("drain");

        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (16 * 5 + 8) @(negedge iCLK);
                iRST_N = 1'b0;
                @(negedge iCLK);
                iRST_N = 1'b1;
            end
        join
        idle(20);
        chk("midrst_data", oDATA, 8'h00);
        check_all("mid_reset");
        send_frame(8'h80, 1'b1);
        model_frame(8'h80, 1'b1, 1'b1);
        idle(5);
        check_all("after_reset");

        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1, 1'b1);
            idle($urandom_range(0, 6));
        end
        idle(10);
        check_all("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
